// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the pedal audio path (transmitter and receiver).
package i2s_pkg;

  localparam int I2S_WIDTH = 24;
  localparam int I2S_SLOT  = 32;

  typedef logic signed [I2S_WIDTH-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } tx_state_t;

endpackage

// File: rtl/i2s_tx_hold.sv
// One-word-per-channel holding buffer for the I2S transmitter, with sticky
// underrun/overrun detection against the shifter's load strobe.
module i2s_tx_hold
  import i2s_pkg::*;
#(
  parameter int WIDTH         = I2S_WIDTH,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  chan_t            wr_chan_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             load_en_i,
  input  chan_t            load_chan_i,
  output logic [WIDTH-1:0] load_word_o,
  output logic             underrun_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] hold_q [2];
  logic [WIDTH-1:0] hold_d [2];
  logic [1:0]       full_q, full_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    hold_d      = hold_q;
    full_d      = full_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    load_word_o = hold_q[load_chan_i];

    if (load_en_i) begin
      full_d[load_chan_i] = 1'b0;
      if (!full_q[load_chan_i]) begin
        underrun_d = 1'b1;
        if (UNDERRUN_ZERO) load_word_o = '0;
      end
    end

    // A write on the load edge of the same channel refills the buffer: the
    // shifter still takes the old word, so it is not an overrun.
    if (wr_en_i) begin
      hold_d[wr_chan_i] = wr_data_i;
      full_d[wr_chan_i] = 1'b1;
      if (full_q[wr_chan_i] && !(load_en_i && (load_chan_i == wr_chan_i)))
        overrun_d = 1'b1;
    end
  end

  // NOTE: the two holding words are reset on purpose: an underrun before any
  // write must repeat a defined zero, not an X.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q[0]  <= '0;
      hold_q[1]  <= '0;
      full_q     <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign underrun_o = underrun_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: slot counter, enable FSM and MSB-first shifter,
// fed from a per-channel holding buffer.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int WIDTH         = I2S_WIDTH,
  parameter int SLOT          = I2S_SLOT,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  input  logic             dchan,
  input  logic             dvalid,
  output logic             lrclk,
  output logic             sdout,
  output logic             frame_start,
  output logic             underrun,
  output logic             overrun
);

  localparam int                FRAME    = 2 * SLOT;
  localparam int                CNT_W    = $clog2(FRAME);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0]  CNT_SLOT = CNT_W'(SLOT);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] sr_q;
  logic             lrclk_q, frame_start_q;
  logic             load_en;
  chan_t            load_chan;
  logic [WIDTH-1:0] load_word;

  assign cnt_inc   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign load_en   = (state_q != IDLE) && ((cnt_q == '0) || (cnt_q == CNT_SLOT));
  assign load_chan = (cnt_q >= CNT_SLOT) ? CH_RIGHT : CH_LEFT;

  // Stopping only at the wrap keeps every emitted frame whole.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (en) begin
          cnt_d = cnt_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
          cnt_d   = cnt_inc;
        end
      end
      DRAIN: begin
        if (en) begin
          state_d = RUN;
          cnt_d   = cnt_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_LAST;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_LAST;
      sr_q          <= '0;
      lrclk_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lrclk_q       <= (cnt_d >= CNT_SLOT);
      frame_start_q <= (cnt_d == '0);
      // Shifting zeros in between loads drives sdout low after the LSB.
      if (load_en) sr_q <= load_word;
      else         sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  i2s_tx_hold #(
    .WIDTH        (WIDTH),
    .UNDERRUN_ZERO(UNDERRUN_ZERO)
  ) u_hold (
    .clk        (sclk),
    .rst_n      (rst),
    .wr_en_i    (dvalid),
    .wr_chan_i  (chan_t'(dchan)),
    .wr_data_i  (data),
    .load_en_i  (load_en),
    .load_chan_i(load_chan),
    .load_word_o(load_word),
    .underrun_o (underrun),
    .overrun_o  (overrun)
  );

  assign lrclk       = lrclk_q;
  assign sdout       = sr_q[WIDTH-1];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: the driver queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_i2s_transmitter;
  import i2s_pkg::*;

  localparam int W  = 24;
  localparam int SL = 32;

  logic         sclk = 1'b0;
  logic         rst, en, dchan, dvalid;
  logic [W-1:0] data;
  logic         lrclk, sdout, frame_start, underrun, overrun;

  i2s_transmitter #(
    .WIDTH        (W),
    .SLOT         (SL),
    .UNDERRUN_ZERO(1'b0)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .en         (en),
    .data       (data),
    .dchan      (dchan),
    .dvalid     (dvalid),
    .lrclk      (lrclk),
    .sdout      (sdout),
    .frame_start(frame_start),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  always #5 sclk = ~sclk;

  // v = {lrclk, sdout, frame_start, underrun, overrun}
  typedef struct {
    logic [4:0] v;
    int         test;
    int         k;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   test_id  = 0;
  logic exp_ur   = 1'b0;
  logic exp_ov   = 1'b0;

  task automatic check(input string name, input int t, input int k,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s test=%0d k=%0d got=%b expected=%b", name, t, k, got, want);
    end
  endtask

  initial forever begin
    @(negedge sclk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("lr_sd_fs_ur_ov", mon_e.test, mon_e.k,
            {27'd0, lrclk, sdout, frame_start, underrun, overrun}, {27'd0, mon_e.v});
    end
  end

  // Queue the expectation for the current cycle, then advance one sclk.
  task automatic tick(input int k, input logic lr, input logic sd, input logic fs);
    exp_q.push_back('{v: {lr, sd, fs, exp_ur, exp_ov}, test: test_id, k: k});
    @(posedge sclk);
    #2;
    dvalid = 1'b0;
  endtask

  task automatic idle_tick();
    tick(-1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_tick(input int k, input logic [W-1:0] l, input logic [W-1:0] r);
    int           s;
    logic [W-1:0] w;
    logic         sd;
    s  = k % SL;
    w  = (k < SL) ? l : r;
    sd = 1'b0;
    if (s >= 1 && s <= W) sd = w[W-s];
    tick(k, k >= SL, sd, k == 0);
  endtask

  task automatic wr(input logic ch, input logic [W-1:0] d);
    dchan  = ch;
    data   = d;
    dvalid = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dvalid = 1'b0; dchan = 1'b0; data = '0;
    @(posedge sclk);
    #2;

    test_id = 0;
    repeat (3) idle_tick();
    rst = 1'b1;
    idle_tick();

    // Basic frame; writes land while idle.
    test_id = 1;
    wr(1'b0, 24'hA5A5A5); idle_tick();
    wr(1'b1, 24'h5A5A5A); idle_tick();
    en = 1'b1;
    idle_tick();
    for (int k = 0; k < 2*SL; k++) run_tick(k, 24'hA5A5A5, 24'h5A5A5A);

    // No writes: stale words repeat, underrun after the first left load.
    test_id = 2;
    for (int k = 0; k < 2*SL; k++) begin
      if (k == 1) exp_ur = 1'b1;
      run_tick(k, 24'hA5A5A5, 24'h5A5A5A);
    end

    // Write on the exact left load edge while full: old word goes out now.
    test_id = 3;
    for (int k = 0; k < 2*SL; k++) begin
      if (k == 10) wr(1'b0, 24'hFFFFFF);
      run_tick(k, 24'hA5A5A5, 24'h5A5A5A);
    end
    for (int k = 0; k < 2*SL; k++) begin
      if (k == 0) wr(1'b0, 24'h123456);
      run_tick(k, 24'hFFFFFF, 24'h5A5A5A);
    end

    // Two left writes before one load: overrun, newest word wins.
    test_id = 4;
    for (int k = 0; k < 2*SL; k++) begin
      if (k == 5) wr(1'b0, 24'h000001);
      if (k == 6) wr(1'b0, 24'h800000);
      if (k == 7) exp_ov = 1'b1;
      run_tick(k, 24'h123456, 24'h5A5A5A);
    end

    // en dropped at cnt=10: frame completes, then idle, then clean restart.
    test_id = 5;
    for (int k = 0; k < 2*SL; k++) begin
      if (k == 10) en = 1'b0;
      run_tick(k, 24'h800000, 24'h5A5A5A);
    end
    wr(1'b0, 24'hF0F0F0); idle_tick();
    wr(1'b1, 24'h0F0F0F); idle_tick();
    idle_tick();
    en = 1'b1;
    idle_tick();
    for (int k = 0; k < 40; k++) run_tick(k, 24'hF0F0F0, 24'h0F0F0F);

    // Asynchronous reset at cnt=40 (sdout is 1 there): checked before the next edge.
    test_id = 6;
    rst = 1'b0; en = 1'b0; exp_ur = 1'b0; exp_ov = 1'b0;
    tick(40, 1'b1, 1'b0, 1'b0);
    repeat (2) idle_tick();
    rst = 1'b1;
    idle_tick();
    wr(1'b0, 24'hC3C3C3); idle_tick();
    wr(1'b1, 24'h3C3C3C); idle_tick();
    en = 1'b1;
    idle_tick();
    for (int k = 0; k < 2*SL; k++) run_tick(k, 24'hC3C3C3, 24'h3C3C3C);

    @(negedge sclk);
    #1;
    check("scoreboard_drained", test_id, -1, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog test=%0d got=timeout expected=finish", test_id);
    $fatal(1, "watchdog expired");
  end

endmodule
